// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard and sequencing controller for the 16-bit
// five-stage pipeline (IF/ID/EX/MEM/WB).
//
// Purpose:
//   - load-use detection (one bubble per hazard, re-evaluated every cycle)
//   - taken-branch flush of IF/ID and ID/EX
//   - multi-cycle EX sequencing: RUN -> BUSY countdown, MULDIV_CYCLES stall cycles
//   - EX operand forwarding selects (MEM over WB)
//   - free-running 16-bit count of stalled cycles for debug
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_*                  ID-stage instruction sources
//   ex_*                  EX-stage destination, sources, load/multi/branch flags
//   mem_rd/_reg_write     MEM destination
//   wb_rd/_reg_write      WB destination
//   stall, ex_hold        hold PC+IF/ID, hold ID/EX+EX
//   flush_if, flush_id    bubble IF/ID, bubble ID/EX
//   fwd_a, fwd_b          00 regfile, 01 MEM, 10 WB
//   resume, state         BUSY countdown and RUN(0)/BUSY(1)
//   stall_cycles          count of cycles with stall=1
//
// Build option: define PIPE_HAZ_R0_ZERO_EN to hardwire register 0 to zero
// (index 0 never matches for hazards or forwarding).

// One forwarding select for one EX operand.
module pipe_hazard_fwd_sel #(
  parameter int REG_BITS = 4,
  parameter bit R0_ZERO  = 1'b0
) (
  input  logic [REG_BITS-1:0] src,
  input  logic [REG_BITS-1:0] mem_rd,
  input  logic                mem_we,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic                wb_we,
  output logic [1:0]          sel
);
  logic src_live;
  assign src_live = !(R0_ZERO && (src == '0));

  always_comb begin
    sel = 2'b00;
    if (src_live && mem_we && (mem_rd == src))     sel = 2'b01;
    else if (src_live && wb_we && (wb_rd == src))  sel = 2'b10;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int REG_BITS      = 4,
  parameter int MULDIV_CYCLES = 4,
  parameter int RESUME_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_uses_rs2,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_to_reg,
  input  logic [REG_BITS-1:0] ex_rs1,
  input  logic [REG_BITS-1:0] ex_rs2,
  input  logic                ex_multi,
  input  logic                ex_branch_taken,
  input  logic [REG_BITS-1:0] mem_rd,
  input  logic                mem_reg_write,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic                wb_reg_write,
  output logic                stall,
  output logic                ex_hold,
  output logic                flush_if,
  output logic                flush_id,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [RESUME_W-1:0] resume,
  output logic                state,
  output logic [15:0]         stall_cycles
);
`ifdef PIPE_HAZ_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_e;

  // First BUSY cycle shows MULDIV_CYCLES-2; the RUN cycle that saw ex_multi
  // plus MULDIV_CYCLES-1 BUSY cycles gives MULDIV_CYCLES stall cycles.
  localparam logic [RESUME_W-1:0] RESUME_INIT = RESUME_W'(MULDIV_CYCLES - 2);

  state_e              state_q, state_d;
  logic [RESUME_W-1:0] resume_q, resume_d;
  logic [15:0]         stall_cycles_q, stall_cycles_d;

  // Forwarding: lane 0 = operand A, lane 1 = operand B.
  logic [1:0][REG_BITS-1:0] ex_src;
  logic [1:0][1:0]          fwd_raw;
  assign ex_src = {ex_rs2, ex_rs1};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    pipe_hazard_fwd_sel #(.REG_BITS(REG_BITS), .R0_ZERO(R0_ZERO)) u_fwd (
      .src    (ex_src[i]),
      .mem_rd (mem_rd),
      .mem_we (mem_reg_write),
      .wb_rd  (wb_rd),
      .wb_we  (wb_reg_write),
      .sel    (fwd_raw[i])
    );
  end

  logic ld_live, rs1_hit, rs2_hit, load_use;
  assign ld_live  = ex_reg_write && ex_mem_to_reg && !(R0_ZERO && (ex_rd == '0));
  assign rs1_hit  = ld_live && (ex_rd == id_rs1);
  assign rs2_hit  = ld_live && id_uses_rs2 && (ex_rd == id_rs2);
  assign load_use = id_valid && (rs1_hit || rs2_hit);

  always_comb begin
    stall          = 1'b0;
    ex_hold        = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    fwd_a          = fwd_raw[0];
    fwd_b          = fwd_raw[1];
    state_d        = state_q;
    resume_d       = resume_q;
    stall_cycles_d = stall_cycles_q;

    if (state_q == BUSY) begin
      // Hazard inputs are ignored while the multi-cycle op drains.
      stall   = 1'b1;
      ex_hold = 1'b1;
      if (resume_q == '0) begin
        state_d  = RUN;
        resume_d = '0;
      end else begin
        resume_d = resume_q - 1'b1;
      end
    end else if (ex_branch_taken) begin
      flush_if = 1'b1;
      flush_id = 1'b1;
    end else if (ex_multi) begin
      stall    = 1'b1;
      ex_hold  = 1'b1;
      state_d  = BUSY;
      resume_d = RESUME_INIT;
    end else if (load_use) begin
      stall    = 1'b1;
      flush_id = 1'b1;
    end

    if (reset) begin
      stall    = 1'b0;
      ex_hold  = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
    end

    if (stall) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      resume_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      resume_q       <= resume_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign state        = state_q;
  assign resume       = resume_q;
  assign stall_cycles = stall_cycles_q;
endmodule
